// File: rtl/operand_fetch_dispatch.sv
// Operand window walker feeding a pair FIFO with round-robin FU issue.
// Optional build macro ZERO_SKIP_EN drops all-zero pairs without issuing them.
module operand_fetch_dispatch #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int NUM_FU     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              preset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [NUM_FU-1:0] fu_ready,
    output logic [NUM_FU-1:0] fu_valid,
    output logic [DATA_W-1:0] operand0,
    output logic [DATA_W-1:0] operand1,
    output logic              zero0,
    output logic              zero1,
    output logic              busy,
    output logic              done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] dp0_q;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] fifo0 [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo1 [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [RW-1:0]     rr_ptr;

    logic              tail;
    logic              last_pair;
    logic              push;
    logic [DATA_W-1:0] push_d1;
    logic              nonempty;
    logic [DATA_W-1:0] head0;
    logic [DATA_W-1:0] head1;
    logic              skip;
    logic              found;
    logic [RW-1:0]     pick;
    logic [RW-1:0]     rr_next;
    logic              issue;
    logic              pop;
    logic [2*NUM_FU-1:0] rdy2;
    logic [NUM_FU-1:0]   rot;

    assign rd_addr0  = dp0_q;
    assign rd_addr1  = dp0_q + ADDR_W'(1);
    assign tail      = (dp0_q == last_q);
    assign last_pair = tail || (rd_addr1 == last_q);
    assign push      = (state_q == FETCH) &&
                       (count < (PW+1)'(FIFO_DEPTH));
    // Odd tail: the word past the window is never consumed
    assign push_d1   = tail ? '0 : rd_data1;
    assign nonempty  = (count != '0);
    assign head0     = fifo0[rd_ptr];
    assign head1     = fifo1[rd_ptr];

`ifdef ZERO_SKIP_EN
    assign skip = nonempty && (head0 == '0) && (head1 == '0);
`else
    assign skip = 1'b0;
`endif

    // Rotate ready so bit 0 is the current round-robin head
    always_comb begin
        rdy2  = {fu_ready, fu_ready};
        rot   = NUM_FU'(rdy2 >> rr_ptr);
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pick  = RW'((int'(rr_ptr) + i) % NUM_FU);
            end
        end
    end

    assign rr_next = RW'((int'(pick) + 1) % NUM_FU);
    assign issue   = nonempty && !skip && found;
    assign pop     = issue || skip;

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: if (push && last_pair) state_d = DRAIN;
            DRAIN: begin
                if ((count == '0) ||
                    ((count == (PW+1)'(1)) && pop))
                    state_d = DONE;
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            dp0_q  <= '0;
            last_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            dp0_q  <= base_addr;
            last_q <= last_addr;
        end else if (push) begin
            dp0_q  <= dp0_q + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo0[wr_ptr] <= rd_data0;
            fifo1[wr_ptr] <= push_d1;
        end
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            fu_valid <= '0;
            operand0 <= '0;
            operand1 <= '0;
            zero0    <= 1'b0;
            zero1    <= 1'b0;
            rr_ptr   <= '0;
        end else if (issue) begin
            fu_valid <= NUM_FU'(1) << pick;
            operand0 <= head0;
            operand1 <= head1;
            zero0    <= (head0 == '0);
            zero1    <= (head1 == '0);
            rr_ptr   <= rr_next;
        end else begin
            fu_valid <= '0;
        end
    end

endmodule
